ex_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide engine in the EX stage; the consuming end of the ID→EX pipeline register.
- Takes the decoded mult/div request and operands registered into EX, and iterates for 32 cycles.
- Writes the HI/LO result registers when finished.
- Drives a stall request back toward the hazard logic so that ID/EX is held while a later mult/div or HI/LO read would see stale state.

---
 rtl/ex_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// -----------------------------------------------------------------------------
// ex_muldiv_unit
//
// Multi-cycle multiply/divide engine at the EX end of the ID/EX pipeline
// register. A MULT/MULTU/DIV/DIVU request is captured in IDLE, iterated for
// WIDTH cycles on operand magnitudes (shift-add multiply, restoring divide),
// sign-corrected in FIX, and committed to HI/LO on the edge leaving FIX.
// A divide by zero skips the iteration and commits on the very next edge.
//
// Ports:
//   clk        pipeline clock, rising edge
//   rst_n      asynchronous active-low reset; aborts any operation in flight
//   MDStart_E  EX-stage mult/div valid, sampled only while IDLE
//   MDOp_E     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SrcA_E     rs operand (multiplicand / dividend), post-forwarding
//   SrcB_E     rt operand (multiplier / divisor), post-forwarding
//   MDInst_D   ID stage holds a mult/div instruction
//   MFHiLo_D   ID stage holds MFHI/MFLO
//   Busy       unit is not IDLE
//   StallMD    Busy & (MDInst_D | MFHiLo_D), hold ID/EX
//   Done       one-cycle pulse, HI/LO were updated on the preceding edge
//   HI, LO     result registers (product high/low, remainder/quotient)
// -----------------------------------------------------------------------------
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MDStart_E,
  input  logic [1:0]       MDOp_E,
  input  logic [WIDTH-1:0] SrcA_E,
  input  logic [WIDTH-1:0] SrcB_E,
  input  logic             MDInst_D,
  input  logic             MFHiLo_D,
  output logic             Busy,
  output logic             StallMD,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  // acc_hi: partial product high half / partial remainder
  // acc_lo: multiplier being shifted out / dividend shifting into quotient
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  // Multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0] opnd_q,   opnd_d;
  logic             is_div_q, is_div_d;
  // neg_lo: negate product (mult) or quotient (div); neg_hi: negate remainder
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic             done_q,   done_d;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic             op_signed;
  logic             op_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_by_zero;

  always_comb begin
    op_signed   = ~MDOp_E[0];
    op_div      = MDOp_E[1];
    a_neg       = op_signed & SrcA_E[WIDTH-1];
    b_neg       = op_signed & SrcB_E[WIDTH-1];
    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no special handling is needed.
    a_mag       = a_neg ? -SrcA_E : SrcA_E;
    b_mag       = b_neg ? -SrcB_E : SrcB_E;
    div_by_zero = op_div & (SrcB_E == '0);
  end

  // ---------------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mult_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;

  always_comb begin
    // Shift-add: add multiplicand when the current multiplier LSB is set,
    // then shift the {carry, hi, lo} concatenation right by one.
    mult_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    // Restoring divide: bring the next dividend bit into the remainder and
    // subtract the divisor if it fits. The shifted remainder can need WIDTH+1
    // bits, but after a successful subtract it is always below the divisor.
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------
  // Sign correction applied on the edge leaving FIX
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod_mag = {acc_hi_q, acc_lo_q};
    prod_neg = -prod_mag;
    if (is_div_q) begin
      fix_lo = neg_lo_q ? -acc_lo_q : acc_lo_q;
      fix_hi = neg_hi_q ? -acc_hi_q : acc_hi_q;
    end else if (neg_lo_q) begin
      fix_hi = prod_neg[2*WIDTH-1:WIDTH];
      fix_lo = prod_neg[WIDTH-1:0];
    end else begin
      fix_hi = acc_hi_q;
      fix_lo = acc_lo_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MDStart_E) begin
          cnt_d    = '0;
          is_div_d = op_div;
          if (div_by_zero) begin
            // Result is fixed: LO all ones, HI the dividend as given.
            // Loaded pre-corrected, so FIX must leave it alone.
            acc_hi_d = SrcA_E;
            acc_lo_d = '1;
            opnd_d   = '0;
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
            state_d  = S_FIX;
          end else begin
            acc_hi_d = '0;
            acc_lo_d = op_div ? a_mag : b_mag;
            opnd_d   = op_div ? b_mag : a_mag;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = op_div & a_neg;
            state_d  = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          acc_hi_d = div_rem;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mult_sum[WIDTH:1];
          acc_lo_d = {mult_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Busy    = (state_q != S_IDLE);
  // Purely from Busy and the ID-stage decode; a start request in EX does not
  // factor in because starts are only accepted while not Busy.
  assign StallMD = Busy & (MDInst_D | MFHiLo_D);
  assign Done    = done_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        MDStart_E;
  logic [1:0]  MDOp_E;
  logic [31:0] SrcA_E;
  logic [31:0] SrcB_E;
  logic        MDInst_D;
  logic        MFHiLo_D;
  logic        Busy;
  logic        StallMD;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MDStart_E (MDStart_E),
    .MDOp_E    (MDOp_E),
    .SrcA_E    (SrcA_E),
    .SrcB_E    (SrcB_E),
    .MDInst_D  (MDInst_D),
    .MFHiLo_D  (MFHiLo_D),
    .Busy      (Busy),
    .StallMD   (StallMD),
    .Done      (Done),
    .HI        (HI),
    .LO        (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Issue one op at a negedge, scramble operands after capture, then watch
  // 40 cycles counting Busy and Done, capturing HI/LO when Done is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int busy_n, output int done_n);
    @(negedge clk);
    MDOp_E = op; SrcA_E = a; SrcB_E = b; MDStart_E = 1'b1;
    @(negedge clk);
    MDStart_E = 1'b0;
    SrcA_E = ~a;
    SrcB_E = b ^ 32'h5A5A_0F0F;
    MDOp_E = ~op;
    busy_n = 0; done_n = 0; hi = 'x; lo = 'x;
    for (int i = 0; i < 40; i++) begin
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        hi = HI;
        lo = LO;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (Done) seen = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] r_hi, r_lo;
    int          r_busy, r_done;
    bit          seen;

    vecs[0]  = '{"multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[1]  = '{"mult_m7x3",    OP_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    vecs[2]  = '{"div_m7d2",     OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{"divu_100d7",   OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[4]  = '{"divu_5d0",     OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1};
    vecs[5]  = '{"div_ovf",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[6]  = '{"div_m9d0",     OP_DIV,   32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF, 1};
    vecs[7]  = '{"mult_minsq",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
    vecs[8]  = '{"mult_7xm1",    OP_MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 33};
    vecs[9]  = '{"div_7dm2",     OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    vecs[10] = '{"multu_x16",    OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 33};
    vecs[11] = '{"divu_maxd1",   OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33};

    rst_n = 1'b0; MDStart_E = 1'b0; MDOp_E = 2'b00; SrcA_E = '0; SrcB_E = '0;
    MDInst_D = 1'b0; MFHiLo_D = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy",  {31'd0, Busy},    32'd0);
    chk("reset_done",  {31'd0, Done},    32'd0);
    chk("reset_stall", {31'd0, StallMD}, 32'd0);
    chk("reset_hi",    HI, 32'd0);
    chk("reset_lo",    LO, 32'd0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r_hi, r_lo, r_busy, r_done);
      chk({vecs[i].name, "_hi"},   r_hi, vecs[i].hi);
      chk({vecs[i].name, "_lo"},   r_lo, vecs[i].lo);
      chk({vecs[i].name, "_busy"}, 32'(r_busy), 32'(vecs[i].busy));
      chk({vecs[i].name, "_done"}, 32'(r_done), 32'd1);
    end

    // Stall behaviour and ignored start while busy. Last result: HI=0, LO=FFFFFFFF.
    @(negedge clk);
    MFHiLo_D = 1'b1;
    #1 chk("stall_idle", {31'd0, StallMD}, 32'd0);
    MFHiLo_D = 1'b0;
    @(negedge clk);
    MDOp_E = OP_MULTU; SrcA_E = 32'd3; SrcB_E = 32'd5; MDStart_E = 1'b1;
    @(negedge clk);
    MDStart_E = 1'b0;
    chk("stall_none", {31'd0, StallMD}, 32'd0);
    MFHiLo_D = 1'b1;
    #1 chk("stall_mfhilo", {31'd0, StallMD}, 32'd1);
    chk("hold_hi", HI, 32'd0);
    chk("hold_lo", LO, 32'hFFFFFFFF);
    MFHiLo_D = 1'b0; MDInst_D = 1'b1;
    #1 chk("stall_mdinst", {31'd0, StallMD}, 32'd1);
    MDInst_D = 1'b0;
    repeat (5) @(negedge clk);
    MDOp_E = OP_MULTU; SrcA_E = 32'd9; SrcB_E = 32'd9; MDStart_E = 1'b1;
    @(negedge clk);
    MDStart_E = 1'b0;
    chk("midcalc_hold_lo", LO, 32'hFFFFFFFF);
    wait_done(seen);
    chk("ignored_start_done", {31'd0, seen}, 32'd1);
    chk("ignored_start_lo", LO, 32'd15);
    chk("ignored_start_hi", HI, 32'd0);

    // Back-to-back: start accepted in the Done cycle.
    MDOp_E = OP_DIVU; SrcA_E = 32'd100; SrcB_E = 32'd9; MDStart_E = 1'b1;
    @(negedge clk);
    MDStart_E = 1'b0;
    chk("b2b_busy", {31'd0, Busy}, 32'd1);
    chk("b2b_done_low", {31'd0, Done}, 32'd0);
    MFHiLo_D = 1'b1;
    wait_done(seen);
    chk("b2b_done", {31'd0, seen}, 32'd1);
    chk("b2b_lo", LO, 32'd11);
    chk("b2b_hi", HI, 32'd1);
    #1 chk("stall_after_done", {31'd0, StallMD}, 32'd0);
    MFHiLo_D = 1'b0;

    // Reset in the middle of CALC aborts the operation.
    @(negedge clk);
    MDOp_E = OP_DIVU; SrcA_E = 32'd1000; SrcB_E = 32'd3; MDStart_E = 1'b1;
    @(negedge clk);
    MDStart_E = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_reset_busy", {31'd0, Busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_busy", {31'd0, Busy}, 32'd0);
    chk("mid_reset_hi", HI, 32'd0);
    chk("mid_reset_lo", LO, 32'd0);
    repeat (2) @(negedge clk);
    chk("mid_reset_done", {31'd0, Done}, 32'd0);
    rst_n = 1'b1;
    run_op(OP_MULTU, 32'd3, 32'd4, r_hi, r_lo, r_busy, r_done);
    chk("post_reset_lo",   r_lo, 32'd12);
    chk("post_reset_hi",   r_hi, 32'd0);
    chk("post_reset_busy", 32'(r_busy), 32'd33);
    chk("post_reset_done", 32'(r_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
